// File: rtl/hwpe_ctrl_demux.sv
// Address-decoding demux from one control port to NrTargets HWPE control slaves.
// An order FIFO of target indices keeps responses in request order; unmapped addresses hit an ERR pseudo-target.
module hwpe_ctrl_demux #(
    parameter int unsigned          NrTargets      = 2,
    parameter int unsigned          AddrWidth      = 32,
    parameter int unsigned          DataWidth      = 32,
    parameter logic [AddrWidth-1:0] BaseAddr       = 32'h0001_0000,
    parameter logic [AddrWidth-1:0] RegionSize     = 32'h100,
    parameter int unsigned          MaxOutstanding = 4,
    parameter int unsigned          NrCores        = 9,
    localparam int unsigned         StrbWidth      = DataWidth / 8,
    localparam int unsigned         OffWidth       = (RegionSize > 1) ? $clog2(RegionSize) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [AddrWidth-1:0]           req_addr_i,
    input  logic                           req_write_i,
    input  logic [DataWidth-1:0]           req_wdata_i,
    input  logic [StrbWidth-1:0]           req_strb_i,
    output logic                           rsp_valid_o,
    output logic [DataWidth-1:0]           rsp_rdata_o,
    output logic                           rsp_error_o,
    output logic [NrTargets-1:0]           tgt_req_valid_o,
    input  logic [NrTargets-1:0]           tgt_req_ready_i,
    output logic [OffWidth-1:0]            tgt_req_addr_o,
    output logic                           tgt_req_write_o,
    output logic [DataWidth-1:0]           tgt_req_wdata_o,
    output logic [StrbWidth-1:0]           tgt_req_strb_o,
    input  logic [NrTargets-1:0]           tgt_rsp_valid_i,
    input  logic [NrTargets*DataWidth-1:0] tgt_rsp_rdata_i,
    input  logic [NrTargets*NrCores-1:0]   tgt_evt_i,
    output logic [NrCores-1:0]             evt_o,
    output logic                           busy_o,
    output logic                           spurious_o
);

    localparam int unsigned IdxWidth = $clog2(NrTargets + 1);
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [IdxWidth-1:0]  ErrIdx  = IdxWidth'(NrTargets);
    localparam logic [CntWidth-1:0]  CntMax  = CntWidth'(MaxOutstanding);
    localparam logic [PtrWidth-1:0]  PtrLast = PtrWidth'(MaxOutstanding - 1);
    localparam logic [AddrWidth:0]   Span    = (AddrWidth + 1)'(NrTargets) * {1'b0, RegionSize};

    logic [IdxWidth-1:0]  fifo_q [MaxOutstanding];
    logic [IdxWidth-1:0]  fifo_d [MaxOutstanding];
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [IdxWidth-1:0]  last_idx_q, last_idx_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_error_q, rsp_error_d;
    logic [NrCores-1:0]   evt_q, evt_d;
    logic                 spurious_q, spurious_d;

    logic [AddrWidth-1:0] addr_off;
    logic                 in_range;
    logic [IdxWidth-1:0]  dec_idx;
    logic [IdxWidth-1:0]  head_idx;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [NrTargets-1:0] head_mask;
    logic                 rsp_hit;
    logic [DataWidth-1:0] head_rdata;
    logic                 head_err;
    logic                 pop;
    logic                 allowed;
    logic                 push;

    always_comb begin
        addr_off = req_addr_i - BaseAddr;
        in_range = (req_addr_i >= BaseAddr) && ({1'b0, addr_off} < Span);
        dec_idx  = in_range ? IdxWidth'(addr_off >> OffWidth) : ErrIdx;
    end

    assign head_idx   = fifo_q[rd_ptr_q];
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CntMax);

    // Only the head target may respond; the ERR head retires on its own.
    always_comb begin
        head_mask  = '0;
        rsp_hit    = 1'b0;
        head_rdata = '0;
        for (int unsigned t = 0; t < NrTargets; t++) begin
            if (!fifo_empty && (head_idx == IdxWidth'(t))) begin
                head_mask[t] = 1'b1;
                rsp_hit      = tgt_rsp_valid_i[t];
                head_rdata   = tgt_rsp_rdata_i[t*DataWidth +: DataWidth];
            end
        end
        head_err = !fifo_empty && (head_idx == ErrIdx);
        pop      = head_err || rsp_hit;
    end

    // A full FIFO still accepts when it pops in the same cycle.
    always_comb begin
        allowed         = !rst_i && (!fifo_full || pop) && (fifo_empty || (dec_idx == last_idx_q));
        tgt_req_valid_o = '0;
        req_ready_o     = 1'b0;
        if (dec_idx == ErrIdx) begin
            req_ready_o = allowed;
        end
        for (int unsigned t = 0; t < NrTargets; t++) begin
            if (dec_idx == IdxWidth'(t)) begin
                tgt_req_valid_o[t] = req_valid_i && allowed;
                req_ready_o        = tgt_req_ready_i[t] && allowed;
            end
        end
        push = req_valid_i && req_ready_o;
    end

    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        last_idx_d = last_idx_q;
        if (push) begin
            fifo_d[wr_ptr_q] = dec_idx;
            wr_ptr_d         = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrWidth'(1);
            last_idx_d       = dec_idx;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrWidth'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        rsp_valid_d = pop;
        rsp_error_d = pop && head_err;
        rsp_rdata_d = (pop && !head_err) ? head_rdata : '0;
        spurious_d  = spurious_q || (|(tgt_rsp_valid_i & ~head_mask));
        evt_d       = '0;
        for (int unsigned t = 0; t < NrTargets; t++) begin
            evt_d = evt_d | tgt_evt_i[t*NrCores +: NrCores];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo_q      <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            last_idx_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            evt_q       <= '0;
            spurious_q  <= 1'b0;
        end else begin
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            last_idx_q  <= last_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            evt_q       <= evt_d;
            spurious_q  <= spurious_d;
        end
    end

    assign tgt_req_addr_o  = addr_off[OffWidth-1:0];
    assign tgt_req_write_o = req_write_i;
    assign tgt_req_wdata_o = req_wdata_i;
    assign tgt_req_strb_o  = req_strb_i;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_rdata_o     = rsp_rdata_q;
    assign rsp_error_o     = rsp_error_q;
    assign evt_o           = evt_q;
    assign busy_o          = (cnt_q != '0);
    assign spurious_o      = spurious_q;

endmodule
